// File: rtl/pwm_generator_verilog_if.sv
// Pin bundle for the PWM block: two push buttons and enable in, one PWM pin out.
// Plain level signals only; there is no valid/ready handshake on this bus.
interface pwm_generator_verilog_if;
  logic increase_duty;
  logic decrease_duty;
  logic ena;
  logic PWM_OUT;

  modport master (
    output increase_duty,
    output decrease_duty,
    output ena,
    input  PWM_OUT
  );

  modport slave (
    input  increase_duty,
    input  decrease_duty,
    input  ena,
    output PWM_OUT
  );
endinterface

// File: rtl/pwm_generator_verilog.sv
// Fixed-period PWM whose duty is stepped by two debounced push buttons;
// duty changes take effect only at period boundaries.
module pwm_generator_verilog #(
  parameter int PERIOD       = 10,
  parameter int DUTY_INIT    = 5,
  parameter int DEBOUNCE_DIV = 2
) (
  input logic                     clk,
  input logic                     rst,
  pwm_generator_verilog_if.slave  bus
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DW = $clog2(PERIOD + 1);
  localparam int VW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

  // Bit 0 = increase button, bit 1 = decrease button throughout.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [VW-1:0] div_q, div_d;
  logic          tick;
  logic [1:0]    samp_new_q, samp_new_d;
  logic [1:0]    samp_old_q, samp_old_d;
  logic [1:0]    deb_q, deb_d;
  logic [1:0]    press;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] active_duty_q, active_duty_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_wrap;
  logic          pwm_q, pwm_d;

  assign btn_raw     = {bus.decrease_duty, bus.increase_duty};
  assign bus.PWM_OUT = pwm_q;

  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    tick       = (div_q == VW'(DEBOUNCE_DIV - 1));
    div_d      = tick ? '0 : div_q + VW'(1);
    samp_new_d = samp_new_q;
    samp_old_d = samp_old_q;
    if (tick) begin
      samp_new_d = sync2_q;
      samp_old_d = samp_new_q;
    end
    // Two agreeing samples set or clear the level; disagreement holds it.
    deb_d = (samp_new_q & samp_old_q) | (deb_q & (samp_new_q | samp_old_q));
    press = deb_d & ~deb_q & {2{bus.ena}};

    duty_d = duty_q;
    if (press == 2'b01 && duty_q < DW'(PERIOD)) begin
      duty_d = duty_q + DW'(1);
    end else if (press == 2'b10 && duty_q != '0) begin
      duty_d = duty_q - DW'(1);
    end

    cnt_wrap      = (cnt_q == CW'(PERIOD - 1));
    cnt_d         = '0;
    active_duty_d = active_duty_q;
    if (bus.ena) begin
      cnt_d = cnt_wrap ? '0 : cnt_q + CW'(1);
      if (cnt_wrap) begin
        active_duty_d = duty_q;
      end
    end
    pwm_d = bus.ena & (DW'(cnt_q) < active_duty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      div_q         <= '0;
      samp_new_q    <= '0;
      samp_old_q    <= '0;
      deb_q         <= '0;
      duty_q        <= DW'(DUTY_INIT);
      active_duty_q <= DW'(DUTY_INIT);
      cnt_q         <= '0;
      pwm_q         <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      div_q         <= div_d;
      samp_new_q    <= samp_new_d;
      samp_old_q    <= samp_old_d;
      deb_q         <= deb_d;
      duty_q        <= duty_d;
      active_duty_q <= active_duty_d;
      cnt_q         <= cnt_d;
      pwm_q         <= pwm_d;
    end
  end

endmodule

// File: tb/tb_pwm_generator_verilog.sv
// Directed bench for pwm_generator_verilog: measures high cycles per period
// against a saturating duty model after each button press.
module tb_pwm_generator_verilog;
  localparam int PERIOD = 10;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   exp_duty;
  logic exp_q[$];

  pwm_generator_verilog_if bus ();

  pwm_generator_verilog #(
    .PERIOD(PERIOD),
    .DUTY_INIT(5),
    .DEBOUNCE_DIV(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic measure(output int highs);
    highs = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      if (bus.PWM_OUT === 1'b1) highs++;
    end
  endtask

  // Drive one press of len cycles; presses of 6+ cycles are guaranteed to count.
  task automatic press(input bit inc, input bit dec, input int len);
    bus.increase_duty = inc;
    bus.decrease_duty = dec;
    step(len);
    bus.increase_duty = 1'b0;
    bus.decrease_duty = 1'b0;
    step(20);
    if (len >= 6 && bus.ena) begin
      if (inc && !dec && exp_duty < PERIOD) exp_duty++;
      else if (dec && !inc && exp_duty > 0) exp_duty--;
    end
  endtask

  task automatic press_and_check(input string tag, input bit inc, input bit dec, input int len);
    int highs;
    press(inc, dec, len);
    measure(highs);
    check(tag, highs, exp_duty);
  endtask

  initial begin
    int highs;
    n_checks = 0;
    n_errors = 0;
    exp_duty = 5;
    rst = 1'b1;
    bus.ena = 1'b1;
    bus.increase_duty = 1'b0;
    bus.decrease_duty = 1'b0;
    step(3);
    check("reset_pwm_low", bus.PWM_OUT, 0);

    // First period after release: high from the first edge, 5 of 10.
    for (int i = 0; i < PERIOD; i++) exp_q.push_back(i < 5);
    rst = 1'b0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      check($sformatf("reset_pattern_%0d", i), bus.PWM_OUT, exp_q.pop_front());
    end
    measure(highs);
    check("default_duty", highs, 5);

    for (int i = 0; i < 3; i++) press_and_check($sformatf("inc_%0d", i), 1'b1, 1'b0, 10);
    for (int i = 0; i < 3; i++) press_and_check($sformatf("dec_%0d", i), 1'b0, 1'b1, 10);

    for (int i = 0; i < 6; i++) press_and_check($sformatf("sat_up_%0d", i), 1'b1, 1'b0, 10);
    press_and_check("sat_hi_hold", 1'b1, 1'b0, 10);
    for (int i = 0; i < 11; i++) press_and_check($sformatf("sat_dn_%0d", i), 1'b0, 1'b1, 10);
    press_and_check("sat_lo_hold", 1'b0, 1'b1, 10);

    press_and_check("inc_from_0a", 1'b1, 1'b0, 10);
    press_and_check("inc_from_0b", 1'b1, 1'b0, 10);
    press_and_check("both_pressed", 1'b1, 1'b1, 10);
    press_and_check("held_200", 1'b1, 1'b0, 200);
    press_and_check("glitch_1", 1'b1, 1'b0, 1);

    // Disabled: output low, presses discarded.
    bus.ena = 1'b0;
    step(2);
    check("ena_off_low", bus.PWM_OUT, 0);
    bus.increase_duty = 1'b1;
    highs = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.PWM_OUT !== 1'b0) highs++;
    end
    bus.increase_duty = 1'b0;
    step(20);
    check("ena_off_no_pulses", highs, 0);
    // Button already held when enable rises must not step.
    bus.increase_duty = 1'b1;
    step(20);
    bus.ena = 1'b1;
    step(20);
    bus.increase_duty = 1'b0;
    step(20);
    measure(highs);
    check("ena_resume_duty", highs, exp_duty);

    // Mid-period reset while PWM is high.
    bus.ena = 1'b0;
    step(2);
    bus.ena = 1'b1;
    step(1);
    check("pre_rst_high", bus.PWM_OUT, 1);
    rst = 1'b1;
    step(1);
    check("mid_rst_low", bus.PWM_OUT, 0);
    rst = 1'b0;
    exp_duty = 5;
    step(1);
    check("post_rst_first_high", bus.PWM_OUT, 1);
    measure(highs);
    check("post_rst_duty", highs, exp_duty);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
